// File: rtl/ex_hazard_ctrl_if.sv
// Pipeline hazard-control bundle: stage status from the datapath, stall/flush/forward controls back.
interface ex_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             i_id_vld;
  logic [4:0]       i_id_rs1_raddr;
  logic [4:0]       i_id_rs2_raddr;
  logic             i_ex_vld;
  logic [4:0]       i_ex_rd_waddr;
  logic             i_ex_rd_wen;
  logic             i_ex_mem_read;
  logic [4:0]       i_ex_rs1_raddr;
  logic [4:0]       i_ex_rs2_raddr;
  logic             i_mem_vld;
  logic [4:0]       i_mem_rd_waddr;
  logic             i_mem_rd_wen;
  logic             i_wb_vld;
  logic [4:0]       i_wb_rd_waddr;
  logic             i_wb_rd_wen;
  logic             i_redirect;
  logic             i_dmem_req;
  logic             i_dmem_ready;
  logic             o_stall_if;
  logic             o_stall_id;
  logic             o_stall_ex;
  logic             o_bubble_ex;
  logic             o_flush_id;
  logic [1:0]       o_fwd_a;
  logic [1:0]       o_fwd_b;
  logic [1:0]       o_state;
  logic             o_dmem_err;
  logic [CNT_W-1:0] o_stall_cycles;

  modport master (
    output i_id_vld, i_id_rs1_raddr, i_id_rs2_raddr,
           i_ex_vld, i_ex_rd_waddr, i_ex_rd_wen, i_ex_mem_read, i_ex_rs1_raddr, i_ex_rs2_raddr,
           i_mem_vld, i_mem_rd_waddr, i_mem_rd_wen,
           i_wb_vld, i_wb_rd_waddr, i_wb_rd_wen,
           i_redirect, i_dmem_req, i_dmem_ready,
    input  o_stall_if, o_stall_id, o_stall_ex, o_bubble_ex, o_flush_id,
           o_fwd_a, o_fwd_b, o_state, o_dmem_err, o_stall_cycles
  );

  modport slave (
    input  i_id_vld, i_id_rs1_raddr, i_id_rs2_raddr,
           i_ex_vld, i_ex_rd_waddr, i_ex_rd_wen, i_ex_mem_read, i_ex_rs1_raddr, i_ex_rs2_raddr,
           i_mem_vld, i_mem_rd_waddr, i_mem_rd_wen,
           i_wb_vld, i_wb_rd_waddr, i_wb_rd_wen,
           i_redirect, i_dmem_req, i_dmem_ready,
    output o_stall_if, o_stall_id, o_stall_ex, o_bubble_ex, o_flush_id,
           o_fwd_a, o_fwd_b, o_state, o_dmem_err, o_stall_cycles
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: operand forwarding, load-use interlock, redirect flush
// and data-memory wait handling with timeout.
module ex_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input logic i_clk,
  input logic i_rst,
  ex_hazard_ctrl_if.slave bus
);
  localparam int WCW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR  = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WCW-1:0]   wait_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic             load_use;
  logic             mem_pending;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (bus.i_mem_vld && bus.i_mem_rd_wen && bus.i_mem_rd_waddr != 5'd0 && bus.i_mem_rd_waddr == rs)
      return 2'b01;
    else if (bus.i_wb_vld && bus.i_wb_rd_wen && bus.i_wb_rd_waddr != 5'd0 && bus.i_wb_rd_waddr == rs)
      return 2'b10;
    else
      return 2'b00;
  endfunction

  always_comb begin
    bus.o_fwd_a = fwd_sel(bus.i_ex_rs1_raddr);
    bus.o_fwd_b = fwd_sel(bus.i_ex_rs2_raddr);
  end

  assign load_use = bus.i_ex_vld && bus.i_ex_mem_read && bus.i_ex_rd_wen &&
                    bus.i_ex_rd_waddr != 5'd0 && bus.i_id_vld &&
                    (bus.i_ex_rd_waddr == bus.i_id_rs1_raddr ||
                     bus.i_ex_rd_waddr == bus.i_id_rs2_raddr);
  assign mem_pending = bus.i_dmem_req && !bus.i_dmem_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = ST_RUN;
    case (state_q)
      ST_RUN:  state_d = mem_pending ? ST_WAIT : ST_RUN;
      ST_WAIT: begin
        if (bus.i_dmem_ready)                         state_d = ST_RUN;
        else if (wait_cnt == WCW'(TIMEOUT - 1))       state_d = ST_ERR;
        else                                          state_d = ST_WAIT;
      end
      ST_ERR:  state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Once memory is not holding the pipe, RUN and the completing MEM_WAIT cycle share
  // the same redirect > load-use priority.
  always_comb begin
    bus.o_stall_if  = 1'b0;
    bus.o_stall_id  = 1'b0;
    bus.o_stall_ex  = 1'b0;
    bus.o_bubble_ex = 1'b0;
    bus.o_flush_id  = 1'b0;
    bus.o_dmem_err  = 1'b0;
    case (state_q)
      ST_RUN, ST_WAIT: begin
        if ((state_q == ST_RUN) ? mem_pending : !bus.i_dmem_ready) begin
          bus.o_stall_if = 1'b1;
          bus.o_stall_id = 1'b1;
          bus.o_stall_ex = 1'b1;
        end else if (bus.i_redirect) begin
          bus.o_flush_id  = 1'b1;
          bus.o_bubble_ex = 1'b1;
        end else if (load_use) begin
          bus.o_stall_if  = 1'b1;
          bus.o_stall_id  = 1'b1;
          bus.o_bubble_ex = 1'b1;
        end
      end
      ST_ERR: begin
        bus.o_dmem_err  = 1'b1;
        bus.o_flush_id  = 1'b1;
        bus.o_bubble_ex = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || state_q != ST_WAIT || state_d != ST_WAIT) wait_cnt <= '0;
    else                                                   wait_cnt <= wait_cnt + WCW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)                                 stall_cnt <= '0;
    else if (bus.o_stall_if && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign bus.o_state        = state_q;
  assign bus.o_stall_cycles = stall_cnt;
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Scoreboard bench: directed scenarios then randomized traffic, checked against a rule-level model.
module tb_ex_hazard_ctrl;
  localparam int TO = 16;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_hazard_ctrl_if #(.CNT_W(CW)) bus ();
  ex_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  typedef struct {
    logic rst;
    logic id_vld; logic [4:0] id_rs1, id_rs2;
    logic ex_vld; logic [4:0] ex_rd; logic ex_wen, ex_mr; logic [4:0] ex_rs1, ex_rs2;
    logic mem_vld; logic [4:0] mem_rd; logic mem_wen;
    logic wb_vld; logic [4:0] wb_rd; logic wb_wen;
    logic redirect, req, ready;
  } stim_t;

  typedef struct {
    logic [4:0] ctl;  // {stall_if, stall_id, stall_ex, bubble_ex, flush_id}
    logic [1:0] fa, fb;
    int         st;
    logic       err;
    int         sc;
  } exp_t;

  exp_t q[$];
  int total = 0, bad = 0;
  int mode = 0, wcnt = 0, scnt = 0;  // mode: 0 RUN, 1 MEM_WAIT, 2 ERR
  int ready_pct = 50;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic logic [1:0] fsel(input stim_t s, input logic [4:0] rs);
    if (s.mem_vld && s.mem_wen && s.mem_rd != 0 && s.mem_rd == rs) return 2'd1;
    if (s.wb_vld && s.wb_rd != 0 && s.wb_wen && s.wb_rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  function automatic exp_t model(input stim_t s);
    exp_t e;
    logic lu;
    logic [4:0] pipe;
    lu = s.ex_vld && s.ex_mr && s.ex_wen && s.ex_rd != 0 && s.id_vld &&
         (s.ex_rd == s.id_rs1 || s.ex_rd == s.id_rs2);
    pipe = s.redirect ? 5'b00011 : (lu ? 5'b11010 : 5'b00000);
    e.fa = fsel(s, s.ex_rs1);
    e.fb = fsel(s, s.ex_rs2);
    e.st = mode;
    e.sc = scnt;
    e.err = (mode == 2);
    if (mode == 0)      e.ctl = (s.req && !s.ready) ? 5'b11100 : pipe;
    else if (mode == 1) e.ctl = !s.ready ? 5'b11100 : pipe;
    else                e.ctl = 5'b00011;
    return e;
  endfunction

  task automatic advance(input stim_t s, input exp_t e);
    if (s.rst) begin
      mode = 0; wcnt = 0; scnt = 0;
    end else begin
      if (e.ctl[4]) scnt = (scnt + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : scnt + 1;
      case (mode)
        0: if (s.req && !s.ready) begin mode = 1; wcnt = 0; end
        1: if (s.ready) mode = 0;
           else if (wcnt == TO - 1) mode = 2;
           else wcnt++;
        default: mode = 0;
      endcase
    end
  endtask

  task automatic cyc(input stim_t s, input bit check);
    exp_t e;
    @(negedge clk);
    rst = s.rst;
    bus.i_id_vld = s.id_vld; bus.i_id_rs1_raddr = s.id_rs1; bus.i_id_rs2_raddr = s.id_rs2;
    bus.i_ex_vld = s.ex_vld; bus.i_ex_rd_waddr = s.ex_rd; bus.i_ex_rd_wen = s.ex_wen;
    bus.i_ex_mem_read = s.ex_mr; bus.i_ex_rs1_raddr = s.ex_rs1; bus.i_ex_rs2_raddr = s.ex_rs2;
    bus.i_mem_vld = s.mem_vld; bus.i_mem_rd_waddr = s.mem_rd; bus.i_mem_rd_wen = s.mem_wen;
    bus.i_wb_vld = s.wb_vld; bus.i_wb_rd_waddr = s.wb_rd; bus.i_wb_rd_wen = s.wb_wen;
    bus.i_redirect = s.redirect; bus.i_dmem_req = s.req; bus.i_dmem_ready = s.ready;
    #1;
    e = model(s);
    if (check) q.push_back(e);
    @(posedge clk);
    advance(s, e);
  endtask

  function automatic stim_t rnd();
    stim_t s;
    s.rst = ($urandom_range(0, 299) == 0);
    s.id_vld = 1'($urandom); s.id_rs1 = 5'($urandom_range(0, 3)); s.id_rs2 = 5'($urandom_range(0, 3));
    s.ex_vld = 1'($urandom); s.ex_rd = 5'($urandom_range(0, 3)); s.ex_wen = 1'($urandom);
    s.ex_mr = 1'($urandom); s.ex_rs1 = 5'($urandom_range(0, 3)); s.ex_rs2 = 5'($urandom_range(0, 3));
    s.mem_vld = 1'($urandom); s.mem_rd = 5'($urandom_range(0, 3)); s.mem_wen = 1'($urandom);
    s.wb_vld = 1'($urandom); s.wb_rd = 5'($urandom_range(0, 3)); s.wb_wen = 1'($urandom);
    s.redirect = ($urandom_range(0, 4) == 0);
    s.req = ($urandom_range(0, 5) == 0);
    s.ready = ($urandom_range(0, 99) < ready_pct);
    return s;
  endfunction

  // Monitor: drains expected entries each cycle and compares against the live outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        chk("ctl", int'({bus.o_stall_if, bus.o_stall_id, bus.o_stall_ex, bus.o_bubble_ex, bus.o_flush_id}), int'(e.ctl));
        chk("fwd_a", int'(bus.o_fwd_a), int'(e.fa));
        chk("fwd_b", int'(bus.o_fwd_b), int'(e.fb));
        chk("state", int'(bus.o_state), e.st);
        chk("dmem_err", int'(bus.o_dmem_err), int'(e.err));
        chk("stall_cycles", int'(bus.o_stall_cycles), e.sc);
      end
    end
  end

  initial begin
    stim_t s;
    s = idle(); s.rst = 1'b1;
    cyc(s, 1'b0);
    cyc(s, 1'b1);
    s = idle();
    cyc(s, 1'b1);
    // load x5 in EX, ID reads x5; then bubble in EX; then dependent op forwarded from MEM
    s = idle(); s.ex_vld = 1; s.ex_mr = 1; s.ex_wen = 1; s.ex_rd = 5; s.id_vld = 1; s.id_rs1 = 5;
    cyc(s, 1'b1);
    s = idle(); s.mem_vld = 1; s.mem_wen = 1; s.mem_rd = 5; s.id_vld = 1; s.id_rs1 = 5;
    cyc(s, 1'b1);
    s = idle(); s.wb_vld = 1; s.wb_wen = 1; s.wb_rd = 5; s.ex_vld = 1; s.ex_rs1 = 5;
    s.mem_vld = 1; s.mem_wen = 1; s.mem_rd = 5;
    cyc(s, 1'b1);
    // MEM and WB both write x3; then both write x0
    s = idle(); s.mem_vld = 1; s.mem_wen = 1; s.mem_rd = 3; s.wb_vld = 1; s.wb_wen = 1; s.wb_rd = 3;
    s.ex_vld = 1; s.ex_rs2 = 3;
    cyc(s, 1'b1);
    s.mem_rd = 0; s.wb_rd = 0; s.ex_rs2 = 0;
    cyc(s, 1'b1);
    // memory ready low for three cycles
    s = idle(); s.req = 1;
    repeat (3) cyc(s, 1'b1);
    s.ready = 1;
    cyc(s, 1'b1);
    s = idle();
    cyc(s, 1'b1);
    // timeout
    s = idle(); s.req = 1;
    repeat (20) cyc(s, 1'b1);
    // redirect with load-use
    s = idle(); s.redirect = 1; s.ex_vld = 1; s.ex_mr = 1; s.ex_wen = 1; s.ex_rd = 7;
    s.id_vld = 1; s.id_rs2 = 7;
    cyc(s, 1'b1);
    // reset mid-wait
    s = idle(); s.req = 1;
    repeat (5) cyc(s, 1'b1);
    s.rst = 1;
    cyc(s, 1'b1);
    s = idle(); s.req = 1;
    cyc(s, 1'b1);
    // randomized traffic with varying memory latency pressure
    for (int blk = 0; blk < 15; blk++) begin
      ready_pct = (blk % 5 == 4) ? 0 : int'($urandom_range(20, 90));
      for (int n = 0; n < 200; n++) cyc(rnd(), 1'b1);
    end
    repeat (2) @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
